// File: rtl/tetris_pkg.sv
// Shared encodings for the game FSM, move scheduler and movement datapath.
package tetris_pkg;

    localparam logic [1:0] CMD_LEFT  = 2'b00;
    localparam logic [1:0] CMD_RIGHT = 2'b01;
    localparam logic [1:0] CMD_ROT   = 2'b10;
    localparam logic [1:0] CMD_DOWN  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_REQ  = 2'b01;
    localparam logic [1:0] ST_DROP = 2'b10;
    localparam logic [1:0] ST_LAND = 2'b11;

    // A period that shifts down to zero still has to tick, so clamp to one cycle.
    function automatic logic [19:0] grav_eff(input logic [19:0] period, input logic [1:0] speed);
        logic [19:0] p;
        p = period >> speed;
        return (p == 20'd0) ? 20'd1 : p;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronized level button.
module btn_edge (
    input  logic clka,
    input  logic restart_n,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) btn_q <= 1'b0;
        else            btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/move_scheduler.sv
// Turns button edges and gravity ticks into single-outstanding movement
// commands towards the datapath, and reports landing to the game FSM.
//
// state | meaning
// IDLE  | no command in flight, picks the highest-priority pending request
// REQ   | one LEFT/RIGHT/ROT/DOWN command waiting for its ack
// DROP  | hard drop: DOWN repeated until the datapath rejects one
// LAND  | one-cycle touched pulse, flush pending requests, restart gravity
module move_scheduler
    import tetris_pkg::*;
#(
    parameter logic [19:0] GRAV_PERIOD = 20'd50000
) (
    input  logic       clka,
    input  logic       restart_n,
    input  logic       start_move,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_drop,
    input  logic [1:0] speed,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    input  logic       cmd_ack,
    input  logic       cmd_ok,
    output logic       touched,
    output logic [1:0] sched_state
);

    logic [1:0]  state;
    logic [19:0] cnt;
    logic [19:0] eff;
    logic        rise_left, rise_right, rise_rot, rise_drop;
    logic        pend_left, pend_right, pend_rot, pend_drop, pend_grav;
    logic        sel_left, sel_right, sel_rot, sel_drop, sel_grav;
    logic        grav_tick, select, keep, accept;

    btn_edge u_edge_left  (.clka(clka), .restart_n(restart_n), .btn(btn_left),  .rise(rise_left));
    btn_edge u_edge_right (.clka(clka), .restart_n(restart_n), .btn(btn_right), .rise(rise_right));
    btn_edge u_edge_rot   (.clka(clka), .restart_n(restart_n), .btn(btn_rot),   .rise(rise_rot));
    btn_edge u_edge_drop  (.clka(clka), .restart_n(restart_n), .btn(btn_drop),  .rise(rise_drop));

    assign eff       = grav_eff(GRAV_PERIOD, speed);
    assign grav_tick = start_move && (cnt == 20'd0);
    assign select    = (state == ST_IDLE) && start_move &&
                       (pend_left || pend_right || pend_rot || pend_drop || pend_grav);
    assign keep      = start_move && (state != ST_LAND);
    assign accept    = (state != ST_DROP);

    always_comb begin
        sel_drop  = 1'b0;
        sel_grav  = 1'b0;
        sel_rot   = 1'b0;
        sel_left  = 1'b0;
        sel_right = 1'b0;
        if (select) begin
            if (pend_drop)      sel_drop  = 1'b1;
            else if (pend_grav) sel_grav  = 1'b1;
            else if (pend_rot)  sel_rot   = 1'b1;
            else if (pend_left) sel_left  = 1'b1;
            else                sel_right = 1'b1;
        end
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n)
            cnt <= 20'd0;
        else if (!start_move || state == ST_LAND || cnt == 20'd0)
            cnt <= eff - 20'd1;
        else
            cnt <= cnt - 20'd1;
    end

    // A new set in the same cycle as the selection wins, so it is served next time round.
    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            pend_left  <= 1'b0;
            pend_right <= 1'b0;
            pend_rot   <= 1'b0;
            pend_drop  <= 1'b0;
            pend_grav  <= 1'b0;
        end else begin
            pend_left  <= keep && ((pend_left  && !sel_left)  || (rise_left  && accept));
            pend_right <= keep && ((pend_right && !sel_right) || (rise_right && accept));
            pend_rot   <= keep && ((pend_rot   && !sel_rot)   || (rise_rot   && accept));
            pend_drop  <= keep && ((pend_drop  && !sel_drop)  || (rise_drop  && accept));
            pend_grav  <= keep && ((pend_grav  && !sel_grav)  || (grav_tick  && accept));
        end
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd       <= CMD_LEFT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (select) begin
                        cmd_valid <= 1'b1;
                        state     <= sel_drop ? ST_DROP : ST_REQ;
                        if (sel_drop || sel_grav) cmd <= CMD_DOWN;
                        else if (sel_rot)         cmd <= CMD_ROT;
                        else if (sel_left)        cmd <= CMD_LEFT;
                        else                      cmd <= CMD_RIGHT;
                    end
                end
                ST_REQ: begin
                    if (cmd_valid && cmd_ack) begin
                        cmd_valid <= 1'b0;
                        state     <= (cmd == CMD_DOWN && !cmd_ok) ? ST_LAND : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (cmd_valid) begin
                        if (cmd_ack) begin
                            cmd_valid <= 1'b0;
                            if (!cmd_ok)          state <= ST_LAND;
                            else if (!start_move) state <= ST_IDLE;
                        end
                    end else if (start_move) begin
                        cmd_valid <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign touched     = (state == ST_LAND);
    assign sched_state = state;

endmodule

// File: tb/tb_move_scheduler.sv
// Randomized self-checking bench for move_scheduler with a reactive datapath model.
module tb_move_scheduler;
    import tetris_pkg::*;

    localparam logic [19:0] GP = 20'd8;

    logic       clka = 1'b0;
    logic       restart_n = 1'b0;
    logic       start_move = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_drop = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       cmd_ack = 1'b0, cmd_ok = 1'b0;
    logic       cmd_valid, touched;
    logic [1:0] cmd, sched_state;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_delay = 0;
    logic ok_default = 1'b1;
    bit   ok_q[$];
    int   hs_cyc[$];
    logic [1:0] hs_cmd[$];
    bit   hs_ok[$];
    int   valid_len[$];
    int   touch_cyc[$];
    int   proto_err = 0;
    int   wait_cnt = 0;
    bit   prev_valid = 0, prev_ack = 0;
    logic [1:0] prev_cmd = 2'b00;

    move_scheduler #(.GRAV_PERIOD(GP)) dut (
        .clka(clka), .restart_n(restart_n), .start_move(start_move),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot), .btn_drop(btn_drop),
        .speed(speed), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ack(cmd_ack), .cmd_ok(cmd_ok),
        .touched(touched), .sched_state(sched_state)
    );

    always #5 clka = ~clka;
    always @(posedge clka) cyc++;

    // Datapath model: acks after ack_delay valid cycles, logs handshakes and touched pulses,
    // and watches that a request is never withdrawn or changed before its ack.
    always @(negedge clka) begin
        if (!restart_n) begin
            cmd_ack = 1'b0;
            wait_cnt = 0;
            prev_valid = 0;
            prev_ack = 0;
        end else begin
            if (prev_valid && !prev_ack && (!cmd_valid || cmd !== prev_cmd)) proto_err++;
            if (prev_valid && prev_ack && cmd_valid) proto_err++;
            if (cmd_valid) begin
                if (wait_cnt >= ack_delay) begin
                    cmd_ack = 1'b1;
                    cmd_ok = (ok_q.size() > 0) ? ok_q.pop_front() : ok_default;
                    hs_cyc.push_back(cyc);
                    hs_cmd.push_back(cmd);
                    hs_ok.push_back(cmd_ok);
                    valid_len.push_back(wait_cnt + 1);
                    wait_cnt = 0;
                end else begin
                    cmd_ack = 1'b0;
                    cmd_ok = 1'($urandom_range(0, 1));
                    wait_cnt++;
                end
            end else begin
                cmd_ack = 1'($urandom_range(0, 1));
                cmd_ok = 1'($urandom_range(0, 1));
                wait_cnt = 0;
            end
            if (touched) touch_cyc.push_back(cyc);
            prev_valid = cmd_valid;
            prev_cmd = cmd;
            prev_ack = cmd_ack;
        end
    end

    function automatic int model_eff(input int sp);
        int e;
        e = int'(GP) >> sp;
        return (e == 0) ? 1 : e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clka);
    endtask

    task automatic clear_log();
        ok_q.delete(); hs_cyc.delete(); hs_cmd.delete(); hs_ok.delete();
        valid_len.delete(); touch_cyc.delete(); proto_err = 0;
    endtask

    task automatic idle_gap();
        start_move = 0; btn_left = 0; btn_right = 0; btn_rot = 0; btn_drop = 0;
        step(3);
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clka);
            if (cmd_valid) begin seen = 1; break; end
        end
    endtask

    task automatic test_reset();
        step(3);
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
        n_checks++; if (cmd !== CMD_LEFT) begin n_fail++; $display("FAIL reset_cmd: got %b expected 00", cmd); end
        n_checks++; if (touched !== 1'b0) begin n_fail++; $display("FAIL reset_touched: got %b expected 0", touched); end
        n_checks++; if (sched_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %b expected 00", sched_state); end
        restart_n = 1;
        step(3);
        n_checks++; if (cmd_valid !== 1'b0 || sched_state !== ST_IDLE) begin
            n_fail++; $display("FAIL post_reset_idle: got valid=%b state=%b expected 0/00", cmd_valid, sched_state); end
    endtask

    task automatic test_gravity();
        int sp_list[4];
        sp_list = '{0, 3, 1, 2};
        for (int it = 0; it < 4; it++) begin
            int eff, d, per, k, bad, first;
            speed = 2'(sp_list[it]);
            eff = model_eff(sp_list[it]);
            d = $urandom_range(0, 3);
            per = (eff > 2 + d) ? eff : 2 + d;
            ack_delay = d; ok_default = 1;
            idle_gap(); clear_log();
            k = cyc; start_move = 1;
            step(6 * eff + 10);
            start_move = 0;
            step(10);
            first = (hs_cyc.size() > 0) ? hs_cyc[0] : -1;
            bad = 0;
            for (int i = 0; i < hs_cyc.size(); i++) begin
                if (hs_cmd[i] !== CMD_DOWN) bad++;
                if (i > 0 && hs_cyc[i] - hs_cyc[i-1] != per) bad++;
            end
            n_checks++; if (hs_cyc.size() < 3) begin n_fail++; $display("FAIL grav_count sp=%0d: got %0d expected >=3", sp_list[it], hs_cyc.size()); end
            n_checks++; if (first != k + eff + 1 + d) begin n_fail++; $display("FAIL grav_first sp=%0d: got %0d expected %0d", sp_list[it], first - k, eff + 1 + d); end
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL grav_period sp=%0d: %0d bad handshakes, expected period %0d", sp_list[it], bad, per); end
            n_checks++; if (touch_cyc.size() != 0) begin n_fail++; $display("FAIL grav_touched: got %0d pulses expected 0", touch_cyc.size()); end
            n_checks++; if (proto_err != 0) begin n_fail++; $display("FAIL grav_protocol: got %0d violations expected 0", proto_err); end
        end
        speed = 2'd0;
    endtask

    task automatic test_buttons();
        for (int it = 0; it < 6; it++) begin
            logic [2:0] mask;
            logic [1:0] exp_q[$];
            int n, d, bad;
            mask = (it == 0) ? 3'b101 : (it == 1) ? 3'b011 : 3'($urandom_range(1, 7));
            if (mask[2]) exp_q.push_back(CMD_ROT);
            if (mask[0]) exp_q.push_back(CMD_LEFT);
            if (mask[1]) exp_q.push_back(CMD_RIGHT);
            n = exp_q.size();
            d = (n == 3) ? 0 : $urandom_range(0, 1);
            idle_gap(); clear_log();
            for (int i = 0; i < n; i++) ok_q.push_back(1'($urandom_range(0, 1)));
            ack_delay = d;
            start_move = 1; btn_left = mask[0]; btn_right = mask[1]; btn_rot = mask[2];
            step(7);
            start_move = 0; btn_left = 0; btn_right = 0; btn_rot = 0;
            step(6);
            bad = 0;
            for (int i = 0; i < hs_cmd.size() && i < n; i++) begin
                if (hs_cmd[i] !== exp_q[i]) bad++;
                if (valid_len[i] != d + 1) bad++;
            end
            n_checks++; if (hs_cmd.size() != n) begin n_fail++; $display("FAIL btn_count mask=%b: got %0d expected %0d", mask, hs_cmd.size(), n); end
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL btn_order mask=%b: %0d wrong cmd/hold, first got %b expected %b", mask, bad, hs_cmd.size() > 0 ? hs_cmd[0] : 2'b00, exp_q[0]); end
            n_checks++; if (touch_cyc.size() != 0) begin n_fail++; $display("FAIL btn_touched: got %0d pulses expected 0", touch_cyc.size()); end
            n_checks++; if (proto_err != 0) begin n_fail++; $display("FAIL btn_protocol: got %0d violations expected 0", proto_err); end
        end
    endtask

    task automatic test_drop();
        for (int it = 0; it < 2; it++) begin
            int n_ok, bad, t_land, t_next, t_last;
            n_ok = (it == 0) ? 3 : $urandom_range(0, 2);
            idle_gap(); clear_log();
            ack_delay = 0; ok_default = 1;
            for (int i = 0; i < n_ok; i++) ok_q.push_back(1'b1);
            ok_q.push_back(1'b0);
            start_move = 1; btn_drop = 1;
            step(1); btn_drop = 0;
            step(2); btn_rot = 1;
            step(1); btn_rot = 0;
            step(26);
            start_move = 0;
            step(6);
            bad = 0;
            for (int i = 0; i < hs_cmd.size(); i++) begin
                if (hs_cmd[i] !== CMD_DOWN) bad++;
                if (i <= n_ok && hs_ok[i] !== (i < n_ok)) bad++;
            end
            t_land = (touch_cyc.size() > 0) ? touch_cyc[0] : -1;
            t_last = (hs_cyc.size() > n_ok) ? hs_cyc[n_ok] : -100;
            t_next = (hs_cyc.size() > n_ok + 1) ? hs_cyc[n_ok + 1] : -1;
            n_checks++; if (touch_cyc.size() != 1) begin n_fail++; $display("FAIL drop_touch_count n_ok=%0d: got %0d expected 1", n_ok, touch_cyc.size()); end
            n_checks++; if (hs_cyc.size() < n_ok + 2) begin n_fail++; $display("FAIL drop_hs_count n_ok=%0d: got %0d expected >=%0d", n_ok, hs_cyc.size(), n_ok + 2); end
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drop_cmds n_ok=%0d: got %0d non-DOWN or wrong ok entries expected 0", n_ok, bad); end
            n_checks++; if (t_land != t_last + 1) begin n_fail++; $display("FAIL drop_touch_time: got %0d expected %0d", t_land, t_last + 1); end
            n_checks++; if (t_next != t_land + int'(GP) + 2) begin n_fail++; $display("FAIL drop_grav_restart: got %0d expected %0d", t_next - t_land, int'(GP) + 2); end
        end
    endtask

    task automatic test_stop();
        bit seen;
        idle_gap(); clear_log();
        ack_delay = 5; ok_default = 1;
        start_move = 1; btn_rot = 1;
        step(1); btn_rot = 0;
        wait_valid(20, seen);
        start_move = 0;
        step(20);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stop_valid_timeout: got %b expected 1", seen); end
        n_checks++; if (hs_cmd.size() != 1 || hs_cmd[0] !== CMD_ROT) begin n_fail++; $display("FAIL stop_single_cmd: got %0d handshakes expected 1 ROT", hs_cmd.size()); end
        n_checks++; if (valid_len.size() != 1 || valid_len[0] != 6) begin n_fail++; $display("FAIL stop_hold: got %0d valid cycles expected 6", valid_len.size() > 0 ? valid_len[0] : 0); end
        n_checks++; if (sched_state !== ST_IDLE || touch_cyc.size() != 0) begin n_fail++; $display("FAIL stop_idle: got state=%b touched=%0d expected 00/0", sched_state, touch_cyc.size()); end

        idle_gap(); clear_log();
        ack_delay = 3; ok_q.push_back(1'b0);
        start_move = 1;
        wait_valid(20, seen);
        start_move = 0;
        step(15);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL stop_land_timeout: got %b expected 1", seen); end
        n_checks++; if (hs_cmd.size() != 1 || hs_cmd[0] !== CMD_DOWN) begin n_fail++; $display("FAIL stop_land_cmd: got %0d handshakes expected 1 DOWN", hs_cmd.size()); end
        n_checks++; if (touch_cyc.size() != 1) begin n_fail++; $display("FAIL stop_land_touch: got %0d expected 1", touch_cyc.size()); end
        n_checks++; if (proto_err != 0 || sched_state !== ST_IDLE) begin n_fail++; $display("FAIL stop_land_end: got proto=%0d state=%b expected 0/00", proto_err, sched_state); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int k, first;
        idle_gap(); clear_log();
        ack_delay = 10;
        start_move = 1; btn_rot = 1;
        wait_valid(20, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_mid_timeout: got %b expected 1", seen); end
        #2 restart_n = 0;
        #1;
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", cmd_valid); end
        n_checks++; if (touched !== 1'b0 || sched_state !== ST_IDLE || cmd !== CMD_LEFT) begin
            n_fail++; $display("FAIL rst_mid_outputs: got touched=%b state=%b cmd=%b expected 0/00/00", touched, sched_state, cmd); end
        start_move = 0; btn_rot = 0;
        step(2);
        restart_n = 1;
        step(2);
        clear_log();
        ack_delay = 0; ok_default = 1;
        k = cyc; start_move = 1;
        step(int'(GP) + 6);
        start_move = 0;
        step(4);
        first = (hs_cyc.size() > 0) ? hs_cyc[0] : -1;
        n_checks++; if (first != k + int'(GP) + 1) begin n_fail++; $display("FAIL rst_restart_first: got %0d expected %0d", first - k, int'(GP) + 1); end
        n_checks++; if (hs_cmd.size() != 1 || hs_cmd[0] !== CMD_DOWN) begin n_fail++; $display("FAIL rst_restart_cmd: got %0d handshakes expected 1 DOWN", hs_cmd.size()); end
    endtask

    initial begin
        test_reset();
        test_gravity();
        test_buttons();
        test_drop();
        test_stop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
